svpwm_gen: RTL and testbench

SVPWM_GEN -- requirements
Module: svpwm_gen

---
 rtl/svpwm_gen.sv | 194 +++++++++++++++++++
 tb/tb_svpwm_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/svpwm_gen.sv
// ============================================================================
// Module  : svpwm_gen
// Brief   : Alpha/beta to three-phase duty converter with center-aligned PWM.
//           Optional min/max zero-sequence injection via SVPWM_MINMAX_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module svpwm_gen #(
  parameter int D_WIDTH    = 32,
  parameter int Q_BITS     = 10,
  parameter int CNT_WIDTH  = 12,
  parameter int PWM_PERIOD = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [D_WIDTH-1:0] alpha,
  input  logic signed [D_WIDTH-1:0] beta,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      duty_a,
  output logic [CNT_WIDTH-1:0]      duty_b,
  output logic [CNT_WIDTH-1:0]      duty_c,
  output logic                      pwm_a,
  output logic                      pwm_b,
  output logic                      pwm_c,
  output logic                      pwm_sync
);

  localparam int PW        = 2 * D_WIDTH;
  localparam int VW        = D_WIDTH + 2;
  localparam int C_SQRT3_2 = $rtoi(0.8660254 * (2.0 ** Q_BITS) + 0.5);
  localparam int C_HALF    = PWM_PERIOD / 2;
  localparam logic [CNT_WIDTH-1:0] C_PEAK = CNT_WIDTH'(PWM_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLARKE = 2'd1,
    S_INJECT = 2'd2,
    S_SCALE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic signed [D_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
  logic signed [VW-1:0]      v_q [3];
  logic signed [VW-1:0]      v_d [3];
  logic [CNT_WIDTH-1:0]      pend_q [3];
  logic [CNT_WIDTH-1:0]      pend_d [3];
  logic [CNT_WIDTH-1:0]      duty_q [3];
  logic [CNT_WIDTH-1:0]      duty_d [3];
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      up_q, up_d;
  logic                      done_q, done_d;
  logic [2:0]                pwm_q, pwm_d;

  logic signed [PW-1:0]      k_full;
  logic signed [VW-1:0]      k_v, a_half, off;
  logic signed [PW-1:0]      scaled [3];
  logic [CNT_WIDTH-1:0]      clamp [3];

`ifdef SVPWM_MINMAX_EN
  logic signed [VW-1:0] v_max, v_min;
  logic signed [VW:0]   mm_sum;

  always_comb begin
    v_max = v_q[0];
    v_min = v_q[0];
    for (int i = 1; i < 3; i++) begin
      if (v_q[i] > v_max) v_max = v_q[i];
      if (v_q[i] < v_min) v_min = v_q[i];
    end
    mm_sum = (VW+1)'(v_max) + (VW+1)'(v_min);
    off    = VW'(mm_sum >>> 1);
  end
`else
  assign off = '0;
`endif

  always_comb begin
    k_full = PW'(C_SQRT3_2) * PW'(beta_q);
    k_v    = VW'(k_full >>> Q_BITS);
    a_half = VW'(alpha_q) >>> 1;
    for (int i = 0; i < 3; i++) begin
      scaled[i] = ((PW'(v_q[i]) * PW'(C_HALF)) >>> Q_BITS) + PW'(C_HALF);
      if (scaled[i][PW-1])
        clamp[i] = '0;
      else if (scaled[i] > PW'(PWM_PERIOD))
        clamp[i] = C_PEAK;
      else
        clamp[i] = CNT_WIDTH'(scaled[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    done_d  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_d[i]    = v_q[i];
      pend_d[i] = pend_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          alpha_d = alpha;
          beta_d  = beta;
          state_d = S_CLARKE;
        end
      end
      S_CLARKE: begin
        v_d[0]  = VW'(alpha_q);
        v_d[1]  = -a_half + k_v;
        v_d[2]  = -a_half - k_v;
        state_d = S_INJECT;
      end
      S_INJECT: begin
        for (int i = 0; i < 3; i++) v_d[i] = v_q[i] - off;
        state_d = S_SCALE;
      end
      default: begin
        for (int i = 0; i < 3; i++) pend_d[i] = clamp[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Triangle carrier: each end value appears exactly once per reversal.
    up_d = up_q;
    if (up_q) begin
      if (cnt_q == C_PEAK) begin
        cnt_d = cnt_q - 1'b1;
        up_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q == '0) begin
      cnt_d = cnt_q + 1'b1;
      up_d  = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end

    for (int i = 0; i < 3; i++) begin
      duty_d[i] = (cnt_q == '0) ? pend_q[i] : duty_q[i];
      pwm_d[i]  = (cnt_d < duty_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      alpha_q <= '0;
      beta_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      up_q    <= 1'b1;
      pwm_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        v_q[i]    <= '0;
        pend_q[i] <= '0;
        duty_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      pwm_q   <= pwm_d;
      for (int i = 0; i < 3; i++) begin
        v_q[i]    <= v_d[i];
        pend_q[i] <= pend_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign duty_a   = duty_q[0];
  assign duty_b   = duty_q[1];
  assign duty_c   = duty_q[2];
  assign pwm_a    = pwm_q[0];
  assign pwm_b    = pwm_q[1];
  assign pwm_c    = pwm_q[2];
  assign pwm_sync = (cnt_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_svpwm_gen.sv
// ============================================================================
// Module  : tb_svpwm_gen
// Brief   : Self-checking bench for svpwm_gen (Q10, period 1000), directed
//           cases plus randomized traffic against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_svpwm_gen;

  logic               clk = 1'b0;
  logic               rst, start;
  logic signed [31:0] alpha, beta;
  logic               busy, done, pwm_a, pwm_b, pwm_c, pwm_sync;
  logic [11:0]        duty_a, duty_b, duty_c;

  int total = 0;
  int bad   = 0;

  int          m_t, m_left, n_done;
  bit          m_done;
  logic [35:0] m_calc, m_pend, m_duty;

  svpwm_gen dut (
    .clk(clk), .rst(rst), .alpha(alpha), .beta(beta), .start(start),
    .busy(busy), .done(done), .duty_a(duty_a), .duty_b(duty_b),
    .duty_c(duty_c), .pwm_a(pwm_a), .pwm_b(pwm_b), .pwm_c(pwm_c),
    .pwm_sync(pwm_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Carrier value as a pure function of cycles since reset.
  function automatic int mcnt(input int t);
    int p;
    p = t % 2000;
    return (p <= 1000) ? p : 2000 - p;
  endfunction

  function automatic logic [35:0] ref_duty(input longint a, input longint b);
    longint v [3];
    longint k, off, mx, mn, d;
    logic [35:0] r;
    k    = (887 * b) >>> 10;
    v[0] = a;
    v[1] = -(a >>> 1) + k;
    v[2] = -(a >>> 1) - k;
    mx = v[0];
    mn = v[0];
    for (int i = 1; i < 3; i++) begin
      if (v[i] > mx) mx = v[i];
      if (v[i] < mn) mn = v[i];
    end
`ifdef SVPWM_MINMAX_EN
    off = (mx + mn) >>> 1;
`else
    off = 0;
`endif
    r = '0;
    for (int i = 0; i < 3; i++) begin
      d = 500 + (((v[i] - off) * 500) >>> 10);
      if (d < 0) d = 0;
      if (d > 1000) d = 1000;
      r[35-12*i -: 12] = 12'(d);
    end
    return r;
  endfunction

  task automatic tick();
    bit          r, s;
    logic [31:0] a, b;
    int          c;
    logic [2:0]  ep;
    r = rst; s = start; a = alpha; b = beta;
    @(posedge clk);
    if (r) begin
      m_t = 0; m_left = 0; m_pend = '0; m_duty = '0; m_done = 0;
    end else begin
      if (mcnt(m_t) == 0) m_duty = m_pend;
      m_done = 0;
      if (m_left == 0) begin
        if (s) begin
          m_left = 3;
          m_calc = ref_duty(longint'(signed'(a)), longint'(signed'(b)));
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_pend = m_calc;
          m_done = 1;
        end
      end
      m_t++;
    end
    #1;
    if (done === 1'b1) n_done++;
    c  = mcnt(m_t);
    ep = {c < m_duty[35:24], c < m_duty[23:12], c < m_duty[11:0]};
    chk("busy", busy, m_left != 0);
    chk("done", done, m_done);
    chk("duty", {duty_a, duty_b, duty_c}, m_duty);
    chk("pwm", {pwm_a, pwm_b, pwm_c}, ep);
    chk("sync", pwm_sync, c == 0);
  endtask

  task automatic conv(input int a, input int b);
    alpha = a; beta = b; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("lat_early", done, 1'b0);
    tick();
    chk("lat", done, 1'b1);
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((m_t % 2000) != ph && n < 2100) begin
      tick();
      n++;
    end
    chk("wait_phase", m_t % 2000, ph);
  endtask

  task automatic load_wait();
    wait_phase(0);
    tick();
  endtask

  initial begin
    int n0, lows, hi_bc, odd_low;
    rst = 1'b1; start = 1'b0; alpha = '0; beta = '0;
    m_t = 0; m_left = 0; n_done = 0; m_done = 0;
    m_calc = '0; m_pend = '0; m_duty = '0;
    tick();
    tick();
    chk("rst_state", {busy, done, pwm_a, pwm_b, pwm_c}, 5'b00000);
    chk("rst_duty", {duty_a, duty_b, duty_c}, 36'd0);
    rst = 1'b0;
    chk("sync_after_rst", pwm_sync, 1'b1);

    conv(0, 0);
    load_wait();
    chk("zero_in", {duty_a, duty_b, duty_c}, {12'd500, 12'd500, 12'd500});

    conv(1024, 0);
    load_wait();
`ifdef SVPWM_MINMAX_EN
    chk("alpha_fs", {duty_a, duty_b, duty_c}, {12'd875, 12'd125, 12'd125});
`else
    chk("alpha_fs", {duty_a, duty_b, duty_c}, {12'd1000, 12'd250, 12'd250});
`endif

    conv(0, 1024);
    load_wait();
    chk("beta_fs", {duty_a, duty_b, duty_c}, {12'd500, 12'd933, 12'd66});

`ifdef SVPWM_MINMAX_EN
    conv(4096, 0);
    load_wait();
    chk("clamp", {duty_a, duty_b, duty_c}, {12'd1000, 12'd0, 12'd0});
    lows = 0; hi_bc = 0; odd_low = 0;
    repeat (2000) begin
      tick();
      if (!pwm_a) begin
        lows++;
        if (mcnt(m_t) != 1000) odd_low++;
      end
      if (pwm_b || pwm_c) hi_bc++;
    end
    chk("clamp_a_lows", lows, 1);
    chk("clamp_a_where", odd_low, 0);
    chk("clamp_bc_high", hi_bc, 0);
`endif

    // Second start while busy must be dropped.
    n0 = n_done;
    alpha = 1024; beta = 0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    alpha = 0; beta = 1024; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("one_done", n_done - n0, 1);

    // Reset mid-conversion aborts with no pulse.
    n0 = n_done;
    alpha = 2000; beta = -700; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_duty", {duty_a, duty_b, duty_c}, 36'd0);
    chk("abort_out", {busy, done, pwm_a, pwm_b, pwm_c}, 5'b00000);
    repeat (8) tick();
    chk("abort_no_done", n_done - n0, 0);

    conv(0, 0);
    load_wait();
    chk("pre_coin", {duty_a, duty_b, duty_c}, {12'd500, 12'd500, 12'd500});

    // done coincident with cnt==0 loads on that very edge.
    wait_phase(1996);
    conv(0, 1024);
    chk("coin_sync", pwm_sync, 1'b1);
    tick();
    chk("coin_load", {duty_a, duty_b, duty_c}, {12'd500, 12'd933, 12'd66});

    // done one cycle late waits a whole carrier period.
    wait_phase(1997);
    conv(0, 0);
    repeat (1998) tick();
    chk("late_hold1", {duty_a, duty_b, duty_c}, {12'd500, 12'd933, 12'd66});
    tick();
    chk("late_hold2", {duty_a, duty_b, duty_c}, {12'd500, 12'd933, 12'd66});
    tick();
    chk("late_load", {duty_a, duty_b, duty_c}, {12'd500, 12'd500, 12'd500});

    for (int i = 0; i < 4000; i++) begin
      alpha = $urandom_range(0, 6000) - 3000;
      beta  = $urandom_range(0, 6000) - 3000;
      start = ($urandom % 6) == 0;
      rst   = ($urandom % 900) == 0;
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
